// File: rtl/legv8_control_unit.sv
`default_nettype none
// ============================================================================
// legv8_control_unit : multi-cycle LEGv8 control FSM producing ControlWord/constant
// Revision 1.0
// ============================================================================

module legv8_control_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic [4:0]  status,
  input  logic [3:0]  current_status,
  output logic [39:0] ControlWord,
  output logic [63:0] constant,
  output logic [2:0]  state,
  output logic        illegal
);

  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01001;
  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_OR    = 5'b00100;
  localparam logic [4:0] FS_XOR   = 5'b01100;
  localparam logic [4:0] FS_PASSB = 5'b11100;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EX0   = 3'd1,
    S_EX1   = 3'd2
  } state_t;

  typedef enum logic [4:0] {
    I_ADD, I_ADDS, I_SUB, I_SUBS, I_AND, I_ORR, I_EOR,
    I_ADDI, I_SUBI, I_LDUR, I_STUR, I_BR, I_MOVZ,
    I_CBZ, I_CBNZ, I_BCOND, I_B, I_BL, I_ILL
  } insn_t;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  insn_t      insn;

  logic [2:0] cgs;
  logic       as_f, pcsel, bsel, il, sl, c0, mw, rw;
  logic [1:0] ds, ps, size;
  logic [4:0] fs, da, sa, sb;
  logic       cond_base, cond_taken;

  logic [4:0] rd, rn, rm;
  assign rd = IR[4:0];
  assign rn = IR[9:5];
  assign rm = IR[20:16];

  // alu_on_bus and the live V/C/N flags are not needed by this control word
  logic unused_ok;
  assign unused_ok = ^{status[0], current_status[3:1]};

  // Wildcard patterns are disjoint; order still lists longest opcodes first
  always_comb begin
    insn = I_ILL;
    casez (IR[31:21])
      11'b10001011000: insn = I_ADD;
      11'b10101011000: insn = I_ADDS;
      11'b11001011000: insn = I_SUB;
      11'b11101011000: insn = I_SUBS;
      11'b10001010000: insn = I_AND;
      11'b10101010000: insn = I_ORR;
      11'b11001010000: insn = I_EOR;
      11'b11111000010: insn = I_LDUR;
      11'b11111000000: insn = I_STUR;
      11'b11010110000: insn = I_BR;
      11'b1001000100?: insn = I_ADDI;
      11'b1101000100?: insn = I_SUBI;
      11'b110100101??: insn = I_MOVZ;
      11'b10110100???: insn = I_CBZ;
      11'b10110101???: insn = I_CBNZ;
      11'b01010100???: insn = I_BCOND;
      11'b000101?????: insn = I_B;
      11'b100101?????: insn = I_BL;
      default:         insn = I_ILL;
    endcase
  end

  // Stored flags {V,C,N,Z} = status[4:1]; odd codes invert, 1110/1111 always
  always_comb begin
    cond_base = 1'b1;
    case (IR[3:1])
      3'b000:  cond_base = status[1];
      3'b001:  cond_base = status[3];
      3'b010:  cond_base = status[2];
      3'b011:  cond_base = status[4];
      3'b100:  cond_base = status[3] & ~status[1];
      3'b101:  cond_base = (status[2] == status[4]);
      3'b110:  cond_base = ~status[1] & (status[2] == status[4]);
      default: cond_base = 1'b1;
    endcase
    cond_taken = cond_base ^ (IR[0] & (IR[3:1] != 3'b111));
  end

  always_comb begin
    cgs       = 3'b000;
    state_d   = S_FETCH;
    as_f      = 1'b1;
    ds        = 2'b00;
    ps        = 2'b00;
    pcsel     = 1'b0;
    bsel      = 1'b0;
    il        = 1'b0;
    sl        = 1'b0;
    fs        = FS_AND;
    c0        = 1'b0;
    size      = 2'b00;
    mw        = 1'b0;
    rw        = 1'b0;
    da        = 5'd0;
    sa        = 5'd0;
    sb        = 5'd0;
    illegal_d = illegal_q;
    case (state_q)
      S_EX0: begin
        case (insn)
          I_ADD, I_ADDS, I_SUB, I_SUBS, I_AND, I_ORR, I_EOR, I_ADDI, I_SUBI: begin
            sa   = rn;
            sb   = rm;
            da   = rd;
            rw   = 1'b1;
            bsel = (insn == I_ADDI) || (insn == I_SUBI);
            sl   = (insn == I_ADDS) || (insn == I_SUBS);
            case (insn)
              I_SUB, I_SUBS, I_SUBI: begin
                fs = FS_SUB;
                c0 = 1'b1;
              end
              I_AND:   fs = FS_AND;
              I_ORR:   fs = FS_OR;
              I_EOR:   fs = FS_XOR;
              default: fs = FS_ADD;
            endcase
          end
          I_LDUR, I_STUR: begin
            sa   = rn;
            bsel = 1'b1;
            cgs  = 3'b001;
            fs   = FS_ADD;
            as_f = 1'b0;
            size = 2'b11;
            if (insn == I_LDUR) begin
              ds      = 2'b11;
              state_d = S_EX1;
            end else begin
              sb = rd;
              ds = 2'b01;
              mw = 1'b1;
            end
          end
          I_BR: begin
            sa    = rn;
            sb    = rn;
            fs    = FS_PASSB;
            ps    = 2'b11;
            pcsel = 1'b1;
          end
          I_B: begin
            ps  = 2'b10;
            cgs = 3'b010;
          end
          I_BL: begin
            ds      = 2'b10;
            rw      = 1'b1;
            da      = 5'd30;
            state_d = S_EX1;
          end
          I_CBZ, I_CBNZ: begin
            sb  = rd;
            fs  = FS_PASSB;
            cgs = 3'b011;
            ps  = (current_status[0] ^ (insn == I_CBNZ)) ? 2'b10 : 2'b00;
          end
          I_BCOND: begin
            cgs = 3'b011;
            ps  = cond_taken ? 2'b10 : 2'b00;
          end
          I_MOVZ: begin
            fs   = FS_PASSB;
            bsel = 1'b1;
            cgs  = 3'b100;
            rw   = 1'b1;
            da   = rd;
          end
          default: illegal_d = 1'b1;
        endcase
      end
      S_EX1: begin
        case (insn)
          I_LDUR: begin
            sa   = rn;
            bsel = 1'b1;
            cgs  = 3'b001;
            fs   = FS_ADD;
            as_f = 1'b0;
            ds   = 2'b11;
            size = 2'b11;
            rw   = 1'b1;
            da   = rd;
          end
          I_BL: begin
            ps  = 2'b10;
            cgs = 3'b010;
          end
          default: ;
        endcase
      end
      default: begin
        ds      = 2'b11;
        il      = 1'b1;
        ps      = 2'b01;
        size    = 2'b10;
        state_d = (state_q == S_FETCH) ? S_EX0 : S_FETCH;
      end
    endcase
  end

  // Branch offsets are word counts and must undo the +4 applied in FETCH
  always_comb begin
    case (cgs)
      3'b000:  constant = {52'd0, IR[21:10]};
      3'b001:  constant = {{55{IR[20]}}, IR[20:12]};
      3'b010:  constant = {{36{IR[25]}}, IR[25:0], 2'b00} - 64'd4;
      3'b011:  constant = {{43{IR[23]}}, IR[23:5], 2'b00} - 64'd4;
      3'b100:  constant = {48'd0, IR[20:5]} << {IR[22:21], 4'b0000};
      default: constant = 64'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign ControlWord = {cgs, state_d, as_f, ds, ps, pcsel, bsel, il, sl, fs, c0,
                        size, mw, rw, da, sa, sb};
  assign state       = state_q;
  assign illegal     = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_legv8_control_unit.sv
`default_nettype none
// ============================================================================
// tb_legv8_control_unit : directed self-checking bench for legv8_control_unit
// Revision 1.0
// ============================================================================

module tb_legv8_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] IR;
  logic [4:0]  status;
  logic [3:0]  current_status;
  logic [39:0] ControlWord;
  logic [63:0] constant;
  logic [2:0]  state;
  logic        illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  legv8_control_unit dut (
    .clock          (clock),
    .reset          (reset),
    .IR             (IR),
    .status         (status),
    .current_status (current_status),
    .ControlWord    (ControlWord),
    .constant       (constant),
    .state          (state),
    .illegal        (illegal)
  );

  localparam logic [39:0] FETCH_WORD = 40'h07A4040000;
  localparam logic [31:0] IR_ADDI    = 32'h910017E1;
  localparam logic [31:0] IR_LDUR    = 32'hF8408043;
  localparam logic [31:0] IR_CBZ     = 32'hB4000062;
  localparam logic [31:0] IR_BEQ     = 32'h54000040;
  localparam logic [31:0] IR_BGT     = 32'h5400004C;
  localparam logic [31:0] IR_SUBS    = 32'hEB0600A4;
  localparam logic [31:0] IR_MOVZ    = 32'hD2A24685;
  localparam logic [31:0] IR_BL      = 32'h94000004;
  localparam logic [31:0] IR_BNEG    = 32'h17FFFFFF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    IR             = 32'd0;
    status         = 5'd0;
    current_status = 4'd0;
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_cw", ControlWord, FETCH_WORD);
    chk("rst_illegal", illegal, 0);
    reset = 1'b1;
    #1;
    chk("rel_state", state, 0);
    chk("rel_cw", ControlWord, FETCH_WORD);

    // ADDI X1, XZR, #5
    IR = IR_ADDI;
    tick();
    chk("addi_state", state, 1);
    chk("addi_sa", ControlWord[9:5], 31);
    chk("addi_da", ControlWord[14:10], 1);
    chk("addi_rw", ControlWord[15], 1);
    chk("addi_bsel", ControlWord[27], 1);
    chk("addi_fs", ControlWord[24:20], 5'b01000);
    chk("addi_sl", ControlWord[25], 0);
    chk("addi_const", constant, 5);
    chk("addi_ns", ControlWord[36:34], 0);
    tick();
    chk("addi_back", state, 0);

    // SUBS X4, X5, X6
    IR = IR_SUBS;
    tick();
    chk("subs_fs", ControlWord[24:20], 5'b01001);
    chk("subs_c0", ControlWord[19], 1);
    chk("subs_sl", ControlWord[25], 1);
    chk("subs_regs", {ControlWord[14:0]}, {5'd4, 5'd5, 5'd6});
    chk("subs_bsel", ControlWord[27], 0);
    tick();

    // LDUR X3, [X2, #8]
    IR = IR_LDUR;
    tick();
    chk("ldur0_state", state, 1);
    chk("ldur0_rw", ControlWord[15], 0);
    chk("ldur0_as", ControlWord[33], 0);
    chk("ldur0_ds", ControlWord[32:31], 2'b11);
    chk("ldur0_size", ControlWord[18:17], 2'b11);
    chk("ldur0_const", constant, 8);
    chk("ldur0_ns", ControlWord[36:34], 2);
    tick();
    chk("ldur1_state", state, 2);
    chk("ldur1_rw", ControlWord[15], 1);
    chk("ldur1_da", ControlWord[14:10], 3);
    chk("ldur1_sa", ControlWord[9:5], 2);
    chk("ldur1_ns", ControlWord[36:34], 0);
    tick();
    chk("ldur_back", state, 0);

    // CBZ X2, #3
    IR = IR_CBZ;
    current_status = 4'b0001;
    tick();
    chk("cbz_z1_ps", ControlWord[30:29], 2'b10);
    chk("cbz_const", constant, 8);
    chk("cbz_sb", ControlWord[4:0], 2);
    chk("cbz_fs", ControlWord[24:20], 5'b11100);
    current_status = 4'b0000;
    #1;
    chk("cbz_z0_ps", ControlWord[30:29], 2'b00);
    tick();

    // B.EQ / B.GT
    IR = IR_BEQ;
    status = 5'b00010;
    tick();
    chk("beq_taken_ps", ControlWord[30:29], 2'b10);
    chk("beq_cgs", ControlWord[39:37], 3'b011);
    chk("beq_const", constant, 4);
    status = 5'b00000;
    #1;
    chk("beq_nt_ps", ControlWord[30:29], 2'b00);
    tick();
    IR = IR_BGT;
    status = 5'b00100;
    tick();
    chk("bgt_nv_ps", ControlWord[30:29], 2'b00);
    status = 5'b00000;
    #1;
    chk("bgt_taken_ps", ControlWord[30:29], 2'b10);
    tick();
    current_status = 4'b0000;

    // MOVZ X5, #0x1234, LSL 16
    IR = IR_MOVZ;
    tick();
    chk("movz_const", constant, 64'h0000_0000_1234_0000);
    chk("movz_da", ControlWord[14:10], 5);
    chk("movz_rw", ControlWord[15], 1);
    chk("movz_fs", ControlWord[24:20], 5'b11100);
    tick();

    // BL #4 (two execute cycles)
    IR = IR_BL;
    tick();
    chk("bl0_ds", ControlWord[32:31], 2'b10);
    chk("bl0_da", ControlWord[14:10], 30);
    chk("bl0_ns", ControlWord[36:34], 2);
    tick();
    chk("bl1_state", state, 2);
    chk("bl1_ps", ControlWord[30:29], 2'b10);
    chk("bl1_rw", ControlWord[15], 0);
    chk("bl1_const", constant, 12);
    tick();
    chk("bl_back", state, 0);

    // B #-1 : negative offset sign extension
    IR = IR_BNEG;
    tick();
    chk("bneg_ps", ControlWord[30:29], 2'b10);
    chk("bneg_const", constant, 64'hFFFF_FFFF_FFFF_FFF8);
    tick();

    // Unsupported opcode
    IR = 32'hFFFFFFFF;
    tick();
    chk("ill_ctrl", {ControlWord[30:29], ControlWord[16:15]}, 4'b0000);
    chk("ill_pre", illegal, 0);
    tick();
    chk("ill_post", illegal, 1);
    chk("ill_state", state, 0);
    IR = IR_ADDI;
    tick();
    tick();
    chk("ill_sticky", illegal, 1);

    // Reset asserted in the middle of LDUR EX1
    IR = IR_LDUR;
    tick();
    tick();
    chk("mid_ex1", state, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_rw", ControlWord[15], 0);
    chk("mid_rst_illegal", illegal, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rel_cw", ControlWord, FETCH_WORD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/legv8_control_unit.md
Name: legv8_control_unit

Overview:
- Multi-cycle control FSM directly upstream of the LEGv8 RAM/ROM datapath wrapper.
- Consumes the instruction register output and the status flags, and produces the 40-bit ControlWord plus the 64-bit constant that drive that wrapper.
- The state register loads the ControlWord NS field every cycle, so sequencing is carried in the word itself.

Parameters:
FS_ADD, 5'b01000, ALU add code (used with C0=0)
FS_SUB, 5'b01001, ALU subtract code (used with C0=1)
FS_AND, 5'b00000, ALU AND code
FS_OR, 5'b00100, ALU OR code
FS_XOR, 5'b01100, ALU XOR code
FS_PASSB, 5'b11100, ALU pass-B code (MOVZ)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; 0 forces state FETCH immediately
IR  input  32  instruction register (datapath IR_out)
status  input  5  {V,C,N,Z,alu_on_bus} stored flags (datapath status)
current_status  input  4  {V,C,N,Z} live ALU flags
ControlWord  output  40  {CGS[2:0],NS[2:0],AS,DS[1:0],PS[1:0],PCsel,Bsel,IL,SL,FS[4:0],C0,size[1:0],MW,RW,DA[4:0],SA[4:0],SB[4:0]}
constant  output  64  immediate for the datapath
state  output  3  current FSM state (visualisation)
illegal  output  1  sticky flag: unsupported opcode seen

Behaviour:
- States: FETCH=0, EX0=1, EX1=2. Values 3–7 behave as FETCH with NS=FETCH.
- state <= ControlWord.NS on the rising clock edge.
- Async reset: state=FETCH, illegal=0. ControlWord and constant are combinational from state/IR/status, so they show the FETCH word while reset is held.
- Idle word: all fields 0 except AS=1 and NS=FETCH.
- FETCH: AS=1, DS=11, IL=1, PS=01 (PC+4), size=10 (32-bit), NS=EX0.
- PS encoding: 00 hold, 01 +4, 10 PC+constant, 11 PC<-data bus.
- PCsel: 0 selects constant, 1 selects bus.
- DS encoding: 00 ALU, 01 B, 10 PC, 11 memory.
- Branch constants compensate for the fetch increment: constant = (sign-extended offset<<2) - 4.
- CGS selects constant:
  - 000: zero-extended IR[21:10]
  - 001: sign-extended IR[20:12]
  - 010: branch IR[25:0]
  - 011: conditional/CBZ IR[23:5]
  - 100: IR[20:5]<<(16*IR[22:21])
  - others: 0
- R-type ADD/SUB/AND/ORR/EOR/ADDS/SUBS (EX0): SA=IR[9:5], SB=IR[20:16], DA=IR[4:0], RW=1, DS=00, NS=FETCH. SL=1 only for ADDS/SUBS.
- ADDI/SUBI (EX0): same as R-type with Bsel=1, CGS=000.
- LDUR:
  - EX0: Bsel=1, CGS=001, FS_ADD, AS=0, DS=11, size=11, NS=EX1.
  - EX1: same address fields plus RW=1, DA=Rt, NS=FETCH. Write occurs only in EX1.
- STUR (EX0): address as LDUR, SB=Rt, DS=01, MW=1, size=11, NS=FETCH.
- B (EX0): PS=10, CGS=010.
- BL:
  - EX0: DS=10, RW=1, DA=30, NS=EX1.
  - EX1: PS=10, CGS=010, NS=FETCH.
- BR (EX0): SA=Rn, DS=00, FS_PASSB with Bsel=0 and SB=Rn, PS=11, PCsel=1.
- CBZ/CBNZ (EX0): SB=Rt, FS_PASSB, DS=00. PS=10 iff current_status Z is 1 (CBZ) or 0 (CBNZ), else PS=00.
- B.cond (EX0): evaluates stored flags status[4:1]. Conditions EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL follow standard ARM semantics. Taken gives PS=10, CGS=011.
- MOVZ (EX0): FS_PASSB, Bsel=1, CGS=100, RW=1, DA=Rd.
- Unsupported opcode in EX0: idle word (no RW/MW/PC change), NS=FETCH, illegal<=1 on that edge. illegal stays set until reset.
- Decode priority: longest opcode match first (11-bit, then 10, 9, 8, 6).

Test Plan:
- Reset held low for 3 cycles, released → state=0, ControlWord=FETCH word (IL=1, PS=01, AS=1, DS=11), illegal=0.
- IR=0x910017E1 (ADDI X1,XZR,#5) in EX0 → SA=31, DA=1, RW=1, Bsel=1, FS=FS_ADD, constant=5, NS=FETCH.
- LDUR X3,[X2,#8] → EX0 has RW=0, AS=0, DS=11, constant=8. EX1 has RW=1, DA=3. Next state is FETCH after exactly 3 cycles total.
- IR=0xB4000062 (CBZ X2,#3):
  - current_status Z=1 → PS=10, constant=8.
  - Z=0 → PS=00.
- B.EQ with status[4:1]=0001 → taken. With 0000 → not taken. B.GT with N≠V → not taken.
- IR=0xFFFFFFFF → no RW/MW/PS activity, illegal=1 after the edge and sticky. Asserting reset mid-LDUR (in EX1) → state=FETCH asynchronously, RW=0 before the next edge.
